// File: rtl/sm83_pkg.sv
// sm83_pkg: shared SM83 types used by the stack engine.
// Holds the stack command and register-pair encodings, the stack FSM state
// encoding, and the mapping from a stack register pair to a 16-bit
// register-file select.
package sm83_pkg;

  typedef enum logic [1:0] {
    STK_PUSH = 2'd0,
    STK_POP  = 2'd1,
    STK_CALL = 2'd2,
    STK_RET  = 2'd3
  } stk_op_t;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2,
    PAIR_AF = 2'd3
  } stk_pair_t;

  typedef enum logic [1:0] {
    R16_BC = 2'd0,
    R16_DE = 2'd1,
    R16_HL = 2'd2,
    R16_SP = 2'd3
  } gp_r16_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEC    = 3'd1,
    ST_WR_HI  = 3'd2,
    ST_WR_LO  = 3'd3,
    ST_RD_LO  = 3'd4,
    ST_RD_HI  = 3'd5,
    ST_COMMIT = 3'd6
  } stk_state_t;

  // AF has no 16-bit GP read/write port (A and F have their own ports),
  // so it maps to BC; the stack engine never uses that select for AF.
  function automatic gp_r16_sel_t stk_pair_to_r16(input stk_pair_t pair);
    case (pair)
      PAIR_BC: return R16_BC;
      PAIR_DE: return R16_DE;
      PAIR_HL: return R16_HL;
      default: return R16_BC;
    endcase
  endfunction

endpackage

// File: rtl/stack_engine.sv
// stack_engine: sequences SM83 PUSH/POP/CALL/RET stack traffic.
// Captures operands from the register file on accept, performs two byte
// memory cycles at SP, then writes SP and the destination back in a single
// COMMIT cycle.
// Optional feature macro: SM83_STACK_CALLRET_EN (CALL/RET execution).
// Without it, CALL/RET are accepted but only pulse err.
module stack_engine
  import sm83_pkg::*;
#(
  parameter bit         DEC_CYCLE = 1'b1,
  parameter logic [7:0] F_MASK    = 8'hF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_pair,
  input  logic [15:0] cmd_target,
  output logic        done,
  output logic        err,
  output logic [1:0]  rf_r_sel16,
  input  logic [15:0] rf_r16,
  input  logic [7:0]  rf_a,
  input  logic [7:0]  rf_f,
  input  logic [15:0] rf_sp,
  input  logic [15:0] rf_pc,
  output logic        rf_wen_sp,
  output logic        rf_wen_gp16,
  output logic        rf_wen_a,
  output logic        rf_wen_f,
  output logic        rf_wen_pc,
  output logic [15:0] rf_w_sp,
  output logic [15:0] rf_w16,
  output logic [15:0] rf_w_pc,
  output logic [1:0]  rf_w_sel16,
  output logic [7:0]  rf_w_a,
  output logic [7:0]  rf_w_f,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

`ifdef SM83_STACK_CALLRET_EN
  localparam bit CALLRET_EN = 1'b1;
`else
  localparam bit CALLRET_EN = 1'b0;
`endif

  stk_state_t  state_reg, state_next;
  stk_op_t     op_reg;
  stk_pair_t   pair_reg;
  logic [15:0] sp_reg, word_reg, target_reg;
  logic        err_reg, err_next;

  stk_op_t   cmd_op_e;
  stk_pair_t cmd_pair_e;
  logic      accept, is_wr_cmd, is_callret_cmd;
  logic [15:0] sp_m1, sp_m2, sp_p1, sp_p2;

  assign cmd_op_e       = stk_op_t'(cmd_op);
  assign cmd_pair_e     = stk_pair_t'(cmd_pair);
  assign accept         = cmd_valid && (state_reg == ST_IDLE);
  assign is_wr_cmd      = (cmd_op_e == STK_PUSH) || (cmd_op_e == STK_CALL);
  assign is_callret_cmd = (cmd_op_e == STK_CALL) || (cmd_op_e == STK_RET);

  // SP arithmetic wraps modulo 2^16 by construction of the 16-bit results.
  assign sp_m1 = sp_reg - 16'd1;
  assign sp_m2 = sp_reg - 16'd2;
  assign sp_p1 = sp_reg + 16'd1;
  assign sp_p2 = sp_reg + 16'd2;

  assign rf_r_sel16 = stk_pair_to_r16(cmd_pair_e);

  // FSM state register and the registered err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

  // Datapath: capture operands on accept, assemble popped bytes on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= STK_PUSH;
      pair_reg   <= PAIR_BC;
      sp_reg     <= 16'h0000;
      word_reg   <= 16'h0000;
      target_reg <= 16'h0000;
    end else begin
      if (accept) begin
        op_reg     <= cmd_op_e;
        pair_reg   <= cmd_pair_e;
        sp_reg     <= rf_sp;
        target_reg <= cmd_target;
        if (cmd_op_e == STK_CALL)
          word_reg <= rf_pc;
        else if (cmd_pair_e == PAIR_AF)
          word_reg <= {rf_a, rf_f};
        else
          word_reg <= rf_r16;
      end
      if (state_reg == ST_RD_LO && mem_ack) word_reg[7:0]  <= mem_rdata;
      if (state_reg == ST_RD_HI && mem_ack) word_reg[15:8] <= mem_rdata;
    end
  end

  // Next-state logic; memory states advance only on the acked edge.
  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_callret_cmd && !CALLRET_EN)
            err_next = 1'b1;
          else if (is_wr_cmd)
            state_next = DEC_CYCLE ? ST_DEC : ST_WR_HI;
          else
            state_next = ST_RD_LO;
        end
      end
      ST_DEC:    state_next = ST_WR_HI;
      ST_WR_HI:  if (mem_ack) state_next = ST_WR_LO;
      ST_WR_LO:  if (mem_ack) state_next = ST_COMMIT;
      ST_RD_LO:  if (mem_ack) state_next = ST_RD_HI;
      ST_RD_HI:  if (mem_ack) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode: bus cycle per memory state, register writes in COMMIT.
  always_comb begin
    cmd_ready   = (state_reg == ST_IDLE);
    err         = err_reg;
    done        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 8'h00;
    rf_wen_sp   = 1'b0;
    rf_wen_gp16 = 1'b0;
    rf_wen_a    = 1'b0;
    rf_wen_f    = 1'b0;
    rf_wen_pc   = 1'b0;
    rf_w_sp     = 16'h0000;
    rf_w16      = 16'h0000;
    rf_w_pc     = 16'h0000;
    rf_w_sel16  = 2'd0;
    rf_w_a      = 8'h00;
    rf_w_f      = 8'h00;
    case (state_reg)
      ST_WR_HI: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_m1;
        mem_wdata = word_reg[15:8];
      end
      ST_WR_LO: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_m2;
        mem_wdata = word_reg[7:0];
      end
      ST_RD_LO: begin
        mem_req  = 1'b1;
        mem_addr = sp_reg;
      end
      ST_RD_HI: begin
        mem_req  = 1'b1;
        mem_addr = sp_p1;
      end
      ST_COMMIT: begin
        done      = 1'b1;
        rf_wen_sp = 1'b1;
        case (op_reg)
          STK_PUSH: rf_w_sp = sp_m2;
          STK_CALL: begin
            rf_w_sp   = sp_m2;
            rf_wen_pc = 1'b1;
            rf_w_pc   = target_reg;
          end
          STK_RET: begin
            rf_w_sp   = sp_p2;
            rf_wen_pc = 1'b1;
            rf_w_pc   = word_reg;
          end
          default: begin
            rf_w_sp = sp_p2;
            if (pair_reg == PAIR_AF) begin
              rf_wen_a = 1'b1;
              rf_w_a   = word_reg[15:8];
              rf_wen_f = 1'b1;
              rf_w_f   = word_reg[7:0] & F_MASK;
            end else begin
              rf_wen_gp16 = 1'b1;
              rf_w_sel16  = stk_pair_to_r16(pair_reg);
              rf_w16      = word_reg;
            end
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: scoreboard bench for stack_engine.
// Stimulus pushes expected bus transfers / commits / err pulses into a
// queue; a monitor pops and compares whenever the DUT shows an event.
module tb_stack_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'd0, cmd_pair = 2'd0;
  logic [15:0] cmd_target = 16'h0000;
  logic        done, err;
  logic [1:0]  rf_r_sel16, rf_w_sel16;
  logic [15:0] rf_r16, rf_sp, rf_pc;
  logic [7:0]  rf_a, rf_f;
  logic        rf_wen_sp, rf_wen_gp16, rf_wen_a, rf_wen_f, rf_wen_pc;
  logic [15:0] rf_w_sp, rf_w16, rf_w_pc;
  logic [7:0]  rf_w_a, rf_w_f;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata = 8'h00;

  // Register file and memory models
  logic [15:0] m_bc = 16'h0, m_de = 16'h0, m_hl = 16'h0, m_sp = 16'h0, m_pc = 16'h0;
  logic [7:0]  m_a = 8'h0, m_f = 8'h0;
  logic [7:0]  mem [0:65535];
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          checks = 0;
  int          errors = 0;

  assign rf_r16 = (rf_r_sel16 == 2'd0) ? m_bc : (rf_r_sel16 == 2'd1) ? m_de :
                  (rf_r_sel16 == 2'd2) ? m_hl : m_sp;
  assign rf_a  = m_a;
  assign rf_f  = m_f;
  assign rf_sp = m_sp;
  assign rf_pc = m_pc;

  stack_engine dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_pair(cmd_pair), .cmd_target(cmd_target), .done(done), .err(err),
    .rf_r_sel16(rf_r_sel16), .rf_r16(rf_r16), .rf_a(rf_a), .rf_f(rf_f),
    .rf_sp(rf_sp), .rf_pc(rf_pc),
    .rf_wen_sp(rf_wen_sp), .rf_wen_gp16(rf_wen_gp16), .rf_wen_a(rf_wen_a),
    .rf_wen_f(rf_wen_f), .rf_wen_pc(rf_wen_pc),
    .rf_w_sp(rf_w_sp), .rf_w16(rf_w16), .rf_w_pc(rf_w_pc),
    .rf_w_sel16(rf_w_sel16), .rf_w_a(rf_w_a), .rf_w_f(rf_w_f),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          kind;   // 0 bus, 1 commit, 2 err
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [4:0]  wen;    // {sp, gp16, a, f, pc}
    logic [15:0] w_sp, w16, w_pc;
    logic [1:0]  sel;
    logic [7:0]  w_a, w_f;
    int          lat;
  } ev_t;

  ev_t exp_q[$];

  function automatic ev_t mk_bus(input string n, input logic we, input logic [15:0] a,
                                 input logic [7:0] d);
    ev_t e;
    e = '{name: n, kind: 0, we: we, addr: a, wdata: d, wen: 5'b0, w_sp: 16'h0, w16: 16'h0,
          w_pc: 16'h0, sel: 2'd0, w_a: 8'h0, w_f: 8'h0, lat: -1};
    return e;
  endfunction

  function automatic ev_t mk_commit(input string n, input logic [4:0] wen, input logic [15:0] sp,
                                    input logic [1:0] sel, input logic [15:0] w16,
                                    input logic [7:0] wa, input logic [7:0] wf,
                                    input logic [15:0] pc, input int lat);
    ev_t e;
    e = '{name: n, kind: 1, we: 1'b0, addr: 16'h0, wdata: 8'h0, wen: wen, w_sp: sp, w16: w16,
          w_pc: pc, sel: sel, w_a: wa, w_f: wf, lat: lat};
    return e;
  endfunction

  function automatic ev_t mk_err(input string n);
    ev_t e;
    e = mk_commit(n, 5'b0, 16'h0, 2'd0, 16'h0, 8'h0, 8'h0, 16'h0, 1);
    e.kind = 2;
    return e;
  endfunction

  task automatic score(input ev_t g);
    ev_t e;
    logic bad;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h wen=%b, required no event",
               g.kind, g.addr, g.wen);
    end else begin
      e = exp_q.pop_front();
      bad = (g.kind != e.kind);
      if (e.kind == 0)
        bad = bad || (g.we !== e.we) || (g.addr !== e.addr) || (e.we && g.wdata !== e.wdata);
      else
        bad = bad || (g.wen !== e.wen) || (e.wen[4] && g.w_sp !== e.w_sp) ||
              (e.wen[3] && (g.sel !== e.sel || g.w16 !== e.w16)) ||
              (e.wen[2] && g.w_a !== e.w_a) || (e.wen[1] && g.w_f !== e.w_f) ||
              (e.wen[0] && g.w_pc !== e.w_pc) || (e.lat >= 0 && g.lat != e.lat);
      if (bad) begin
        errors++;
        $display("FAIL %s: got kind=%0d we=%b addr=%h wd=%h wen=%b sp=%h sel=%0d w16=%h a=%h f=%h pc=%h lat=%0d; required kind=%0d we=%b addr=%h wd=%h wen=%b sp=%h sel=%0d w16=%h a=%h f=%h pc=%h lat=%0d",
                 e.name, g.kind, g.we, g.addr, g.wdata, g.wen, g.w_sp, g.sel, g.w16, g.w_a,
                 g.w_f, g.w_pc, g.lat, e.kind, e.we, e.addr, e.wdata, e.wen, e.w_sp, e.sel,
                 e.w16, e.w_a, e.w_f, e.w_pc, e.lat);
      end
    end
  endtask

  // Memory responder: acks after wait_cycles idle request cycles
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (wcnt >= wait_cycles) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Register file model: applies COMMIT writes
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rf_wen_sp) m_sp = rf_w_sp;
        if (rf_wen_pc) m_pc = rf_w_pc;
        if (rf_wen_a)  m_a  = rf_w_a;
        if (rf_wen_f)  m_f  = rf_w_f;
        if (rf_wen_gp16) begin
          case (rf_w_sel16)
            2'd0: m_bc = rf_w16;
            2'd1: m_de = rf_w16;
            2'd2: m_hl = rf_w16;
            default: m_sp = rf_w16;
          endcase
        end
      end
    end
  end

  // Monitor: bus hold stability, bus transfers, commits, err pulses
  initial begin
    logic        pend;
    logic        p_we;
    logic [15:0] p_addr;
    logic [7:0]  p_wdata;
    ev_t         g;
    pend = 1'b0; p_we = 1'b0; p_addr = 16'h0; p_wdata = 8'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (mem_req) begin
          if (pend) begin
            checks++;
            if (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wdata)) begin
              errors++;
              $display("FAIL bus_hold: got we=%b addr=%h wd=%h, required we=%b addr=%h wd=%h",
                       mem_we, mem_addr, mem_wdata, p_we, p_addr, p_wdata);
            end
          end
          if (mem_ack) begin
            g = mk_bus("bus", mem_we, mem_addr, mem_wdata);
            if (mem_we) mem[mem_addr] = mem_wdata;
            score(g);
            pend = 1'b0;
          end else begin
            pend = 1'b1; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
          end
        end else begin
          pend = 1'b0;
        end
        if (done) begin
          g = mk_commit("commit", {rf_wen_sp, rf_wen_gp16, rf_wen_a, rf_wen_f, rf_wen_pc},
                        rf_w_sp, rf_w_sel16, rf_w16, rf_w_a, rf_w_f, rf_w_pc, cyc - accept_cyc);
          score(g);
        end
        if (err) begin
          g = mk_err("err");
          g.lat = cyc - accept_cyc;
          score(g);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] pair, input logic [15:0] tgt,
                       input bit expect_err);
    bit ready_bad;
    int n;
    @(negedge clk); #2;
    cmd_op = op; cmd_pair = pair; cmd_target = tgt; cmd_valid = 1'b1;
    accept_cyc = cyc;
    @(negedge clk); #2;
    cmd_valid = 1'b0;
    ready_bad = 1'b0;
    n = 0;
    while (!(done || err) && n < 100) begin
      if (cmd_ready) ready_bad = 1'b1;
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL completion_timeout: got no done/err in %0d cycles, required done or err", n);
    end
    if (!expect_err) begin
      checks++;
      if (ready_bad) begin
        errors++;
        $display("FAIL cmd_ready_busy: got cmd_ready=1 while busy, required 0");
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string n);
    logic [31:0] v;
    v = {cmd_ready, mem_req, mem_we, done, err, rf_wen_sp, rf_wen_gp16, rf_wen_a, rf_wen_f,
         rf_wen_pc, mem_addr, 6'b0};
    checks++;
    if (v !== {1'b1, 31'b0}) begin
      errors++;
      $display("FAIL %s: got ready/req/we/done/err/wens/addr=%h, required %h", n, v, {1'b1, 31'b0});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    check_idle_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // PUSH BC, BC=1234, SP=FFFE
    m_bc = 16'h1234; m_sp = 16'hFFFE;
    exp_q.push_back(mk_bus("push_bc_hi", 1'b1, 16'hFFFD, 8'h12));
    exp_q.push_back(mk_bus("push_bc_lo", 1'b1, 16'hFFFC, 8'h34));
    exp_q.push_back(mk_commit("push_bc_commit", 5'b10000, 16'hFFFC, 2'd0, 16'h0, 8'h0, 8'h0, 16'h0, 4));
    issue(2'd0, 2'd0, 16'h0000, 1'b0);

    // POP AF, SP=FFFC, [FFFC]=FF [FFFD]=5A
    m_sp = 16'hFFFC; mem[16'hFFFC] = 8'hFF; mem[16'hFFFD] = 8'h5A;
    exp_q.push_back(mk_bus("pop_af_lo", 1'b0, 16'hFFFC, 8'h00));
    exp_q.push_back(mk_bus("pop_af_hi", 1'b0, 16'hFFFD, 8'h00));
    exp_q.push_back(mk_commit("pop_af_commit", 5'b10110, 16'hFFFE, 2'd0, 16'h0, 8'h5A, 8'hF0, 16'h0, 3));
    issue(2'd1, 2'd3, 16'h0000, 1'b0);

    // POP HL with 3 wait cycles per transfer
    wait_cycles = 3;
    m_sp = 16'hFFFE; mem[16'hFFFE] = 8'hCD; mem[16'hFFFF] = 8'hAB;
    exp_q.push_back(mk_bus("pop_hl_lo", 1'b0, 16'hFFFE, 8'h00));
    exp_q.push_back(mk_bus("pop_hl_hi", 1'b0, 16'hFFFF, 8'h00));
    exp_q.push_back(mk_commit("pop_hl_commit", 5'b11000, 16'h0000, 2'd2, 16'hABCD, 8'h0, 8'h0, 16'h0, -1));
    issue(2'd1, 2'd2, 16'h0000, 1'b0);
    wait_cycles = 0;

    // PUSH DE at SP=0000 wraps
    m_sp = 16'h0000; m_de = 16'hBEEF;
    exp_q.push_back(mk_bus("push_de_hi", 1'b1, 16'hFFFF, 8'hBE));
    exp_q.push_back(mk_bus("push_de_lo", 1'b1, 16'hFFFE, 8'hEF));
    exp_q.push_back(mk_commit("push_de_commit", 5'b10000, 16'hFFFE, 2'd0, 16'h0, 8'h0, 8'h0, 16'h0, 4));
    issue(2'd0, 2'd1, 16'h0000, 1'b0);

    // POP BC at SP=FFFF wraps
    m_sp = 16'hFFFF; mem[16'hFFFF] = 8'hBE; mem[16'h0000] = 8'h77;
    exp_q.push_back(mk_bus("pop_bc_lo", 1'b0, 16'hFFFF, 8'h00));
    exp_q.push_back(mk_bus("pop_bc_hi", 1'b0, 16'h0000, 8'h00));
    exp_q.push_back(mk_commit("pop_bc_commit", 5'b11000, 16'h0001, 2'd0, 16'h77BE, 8'h0, 8'h0, 16'h0, 3));
    issue(2'd1, 2'd0, 16'h0000, 1'b0);

    // PUSH AF captures {A,F}
    m_sp = 16'hFFFE; m_a = 8'h5A; m_f = 8'hF0;
    exp_q.push_back(mk_bus("push_af_hi", 1'b1, 16'hFFFD, 8'h5A));
    exp_q.push_back(mk_bus("push_af_lo", 1'b1, 16'hFFFC, 8'hF0));
    exp_q.push_back(mk_commit("push_af_commit", 5'b10000, 16'hFFFC, 2'd0, 16'h0, 8'h0, 8'h0, 16'h0, 4));
    issue(2'd0, 2'd3, 16'h0000, 1'b0);

    // CALL 0150 from PC=0203, SP=D000
    m_sp = 16'hD000; m_pc = 16'h0203;
`ifdef SM83_STACK_CALLRET_EN
    exp_q.push_back(mk_bus("call_hi", 1'b1, 16'hCFFF, 8'h02));
    exp_q.push_back(mk_bus("call_lo", 1'b1, 16'hCFFE, 8'h03));
    exp_q.push_back(mk_commit("call_commit", 5'b10001, 16'hCFFE, 2'd0, 16'h0, 8'h0, 8'h0, 16'h0150, 4));
    issue(2'd2, 2'd0, 16'h0150, 1'b0);
`else
    exp_q.push_back(mk_err("call_err"));
    issue(2'd2, 2'd0, 16'h0150, 1'b1);
`endif

    // RET from SP=CFFE holding 0203
    m_sp = 16'hCFFE; mem[16'hCFFE] = 8'h03; mem[16'hCFFF] = 8'h02;
`ifdef SM83_STACK_CALLRET_EN
    exp_q.push_back(mk_bus("ret_lo", 1'b0, 16'hCFFE, 8'h00));
    exp_q.push_back(mk_bus("ret_hi", 1'b0, 16'hCFFF, 8'h00));
    exp_q.push_back(mk_commit("ret_commit", 5'b10001, 16'hD000, 2'd0, 16'h0, 8'h0, 8'h0, 16'h0203, 3));
    issue(2'd3, 2'd0, 16'h0000, 1'b0);
`else
    exp_q.push_back(mk_err("ret_err"));
    issue(2'd3, 2'd0, 16'h0000, 1'b1);
`endif

    // Reset during WR_LO of PUSH HL
    wait_cycles = 2;
    m_sp = 16'hD000; m_hl = 16'hABCD;
    exp_q.push_back(mk_bus("rst_push_hi", 1'b1, 16'hCFFF, 8'hAB));
    @(negedge clk); #2;
    cmd_op = 2'd0; cmd_pair = 2'd2; cmd_valid = 1'b1; accept_cyc = cyc;
    @(negedge clk); #2;
    cmd_valid = 1'b0;
    n = 0;
    while (!(mem_req && mem_addr == 16'hCFFE) && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL rst_reach_wr_lo: got no WR_LO in %0d cycles, required WR_LO", n);
    end
    rst = 1'b1;
    @(negedge clk); #2;
    check_idle_outputs("rst_mid_op");
    rst = 1'b0;
    wait_cycles = 0;
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (m_sp !== 16'hD000) begin
      errors++;
      $display("FAIL rst_sp_unchanged: got SP=%h, required D000", m_sp);
    end

    // All expected events consumed
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending, required 0 (next %s)",
               exp_q.size(), exp_q[0].name);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
